// File: rtl/bsg_cgol_pkg.sv
// Shared types and constants for the Game-of-Life board engine.
package bsg_cgol_pkg;

    typedef enum logic [1:0] {
        eIdle = 2'd0,
        eRun  = 2'd1,
        eDone = 2'd2
    } cgol_state_e;

    // Conway rule B3/S23
    localparam logic [8:0] birth_mask_def_lp   = 9'b0_0000_1000;
    localparam logic [8:0] survive_mask_def_lp = 9'b0_0000_1100;

    localparam int unsigned nbr_cnt_width_lp = 4;

endpackage

// File: rtl/bsg_cgol_rule_cell.sv
// One board cell: state flop with seed load / generation step, neighbour count and rule lookup.
module bsg_cgol_rule_cell
    import bsg_cgol_pkg::*;
#(
    parameter logic [8:0] birth_mask_p   = birth_mask_def_lp,
    parameter logic [8:0] survive_mask_p = survive_mask_def_lp
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic       load_i,
    input  logic       seed_i,
    input  logic       step_i,
    input  logic [7:0] nbr_i,
    output logic       live_o
);

    logic                              live_q;
    logic                              live_d;
    logic [nbr_cnt_width_lp-1:0]       nbr_cnt_c;

    always_comb begin
        nbr_cnt_c = '0;
        for (int i = 0; i < 8; i++) begin
            nbr_cnt_c = nbr_cnt_c + nbr_cnt_width_lp'(nbr_i[i]);
        end
    end

    // Load has priority; it only coincides with step when the FSM is misused.
    always_comb begin
        live_d = live_q;
        if (load_i) begin
            live_d = seed_i;
        end else if (step_i) begin
            live_d = live_q ? survive_mask_p[nbr_cnt_c] : birth_mask_p[nbr_cnt_c];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            live_q <= 1'b0;
        end else begin
            live_q <= live_d;
        end
    end

    assign live_o = live_q;

endmodule

// File: rtl/bsg_cgol_board.sv
// Game-of-Life board: seed load, N-generation evolution, result handshake.
// Define BSG_CGOL_TORUS_EN for a toroidal board; otherwise border neighbours are dead.
module bsg_cgol_board
    import bsg_cgol_pkg::*;
#(
    parameter int unsigned width_p        = 8,
    parameter int unsigned height_p       = 8,
    parameter int unsigned max_gens_p     = 255,
    parameter logic [8:0]  birth_mask_p   = birth_mask_def_lp,
    parameter logic [8:0]  survive_mask_p = survive_mask_def_lp,
    localparam int unsigned gen_width_lp  = $clog2(max_gens_p + 1),
    localparam int unsigned cells_lp      = width_p * height_p
) (
    input  logic                    clk_i,
    input  logic                    reset,
    input  logic                    v_i,
    output logic                    ready_o,
    input  logic [cells_lp-1:0]     data_i,
    input  logic [gen_width_lp-1:0] gens_i,
    output logic                    v_o,
    output logic [cells_lp-1:0]     data_o,
    input  logic                    yumi_i
);

    cgol_state_e               state_q, state_d;
    logic [gen_width_lp-1:0]   cnt_q, cnt_d;
    logic                      load_c;
    logic                      step_c;
    logic [cells_lp-1:0]       board;

    // Board padded by one ring; ring cells are dead or wrapped copies.
    logic ext [height_p+2][width_p+2];

    for (genvar er = 0; er < height_p + 2; er++) begin : g_ext_r
        for (genvar ec = 0; ec < width_p + 2; ec++) begin : g_ext_c
            localparam int unsigned rr_lp = (er == 0) ? height_p - 1 :
                                            (er == height_p + 1) ? 0 : er - 1;
            localparam int unsigned cc_lp = (ec == 0) ? width_p - 1 :
                                            (ec == width_p + 1) ? 0 : ec - 1;
            localparam bit inside_lp = (er != 0) && (er != height_p + 1) &&
                                       (ec != 0) && (ec != width_p + 1);
            if (inside_lp) begin : g_in
                assign ext[er][ec] = board[rr_lp*width_p + cc_lp];
            end else begin : g_ring
`ifdef BSG_CGOL_TORUS_EN
                assign ext[er][ec] = board[rr_lp*width_p + cc_lp];
`else
                assign ext[er][ec] = 1'b0;
`endif
            end
        end
    end

    for (genvar r = 0; r < height_p; r++) begin : g_row
        for (genvar c = 0; c < width_p; c++) begin : g_col
            logic [7:0] nbr;
            assign nbr = {ext[r][c],   ext[r][c+1],   ext[r][c+2],
                          ext[r+1][c],                ext[r+1][c+2],
                          ext[r+2][c], ext[r+2][c+1], ext[r+2][c+2]};

            bsg_cgol_rule_cell #(
                .birth_mask_p   (birth_mask_p),
                .survive_mask_p (survive_mask_p)
            ) u_cell (
                .clk_i  (clk_i),
                .reset  (reset),
                .load_i (load_c),
                .seed_i (data_i[r*width_p + c]),
                .step_i (step_c),
                .nbr_i  (nbr),
                .live_o (board[r*width_p + c])
            );
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        unique case (state_q)
            eIdle: begin
                if (v_i) begin
                    load_c  = 1'b1;
                    cnt_d   = gens_i;
                    state_d = (gens_i != '0) ? eRun : eDone;
                end
            end
            eRun: begin
                step_c = 1'b1;
                cnt_d  = cnt_q - gen_width_lp'(1);
                if (cnt_q == gen_width_lp'(1)) begin
                    state_d = eDone;
                end
            end
            eDone: begin
                if (yumi_i) begin
                    state_d = eIdle;
                end
            end
            default: state_d = eIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= eIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs are held low for the whole reset pulse, not just after it.
    assign ready_o = ~reset & (state_q == eIdle);
    assign v_o     = ~reset & (state_q == eDone);
    assign data_o  = board;

    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset) yumi_i |-> v_o)
        else $error("bsg_cgol_board: yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_cgol_board.sv
// Directed self-checking bench for bsg_cgol_board (default rule and a B2/S- instance).
module tb_bsg_cgol_board;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_i, ready_o, v_o, yumi_i;
    logic [63:0] data_i, data_o;
    logic [7:0]  gens_i;
    logic        v2_i, ready2_o, v2_o, yumi2_i;
    logic [63:0] data2_i, data2_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_cgol_board dut (
        .clk_i(clk), .reset(reset), .v_i(v_i), .ready_o(ready_o),
        .data_i(data_i), .gens_i(gens_i), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
    );

    bsg_cgol_board #(.birth_mask_p(9'b0_0000_0100), .survive_mask_p(9'b0)) dut_b2 (
        .clk_i(clk), .reset(reset), .v_i(v2_i), .ready_o(ready2_o),
        .data_i(data2_i), .gens_i(gens_i), .v_o(v2_o), .data_o(data2_o), .yumi_i(yumi2_i)
    );

    typedef struct {
        string       name;
        logic [63:0] seed;
        logic [7:0]  gens;
        logic [63:0] exp;
    } vec_t;

    function automatic logic [63:0] pt(input int r, input int c);
        return 64'(1) << (r * 8 + c);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, presents one seed, returns just after the accepting edge.
    task automatic start_job(input string nm, input logic [63:0] seed, input logic [7:0] gens);
        int k = 0;
        while (!ready_o && k < 50) begin
            tick();
            k++;
        end
        chk({nm, " ready_before"}, 64'(ready_o), 64'd1);
        data_i = seed;
        gens_i = gens;
        v_i    = 1'b1;
        tick();
        v_i    = 1'b0;
        chk({nm, " ready_after_accept"}, 64'(ready_o), 64'd0);
    endtask

    task automatic wait_done(input string nm, input int exp_lat);
        int k = 0;
        while (!v_o && k < 300) begin
            tick();
            k++;
        end
        chk({nm, " latency"}, 64'(k), 64'(exp_lat));
    endtask

    task automatic release_result(input string nm);
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        chk({nm, " ready_after_yumi"}, 64'(ready_o), 64'd1);
        chk({nm, " v_after_yumi"}, 64'(v_o), 64'd0);
    endtask

    task automatic run_job(input vec_t v);
        start_job(v.name, v.seed, v.gens);
        wait_done(v.name, int'(v.gens));
        chk({v.name, " board"}, data_o, v.exp);
        release_result(v.name);
    endtask

    vec_t vecs[8];
    logic [63:0] blinker_h, blinker_v, block, glider, edge_h, frozen;
    int k;

    initial begin
        blinker_h = pt(3,2) | pt(3,3) | pt(3,4);
        blinker_v = pt(2,3) | pt(3,3) | pt(4,3);
        block     = pt(1,1) | pt(1,2) | pt(2,1) | pt(2,2);
        glider    = pt(0,1) | pt(1,2) | pt(2,0) | pt(2,1) | pt(2,2);
        edge_h    = pt(0,2) | pt(0,3) | pt(0,4);

        vecs[0] = '{"blinker_g1", blinker_h, 8'd1, blinker_v};
        vecs[1] = '{"blinker_g2", blinker_h, 8'd2, blinker_h};
        vecs[2] = '{"blinker_g3", blinker_h, 8'd3, blinker_v};
        vecs[3] = '{"block_g10",  block,     8'd10, block};
        vecs[4] = '{"block_g0",   block,     8'd0,  block};
        vecs[5] = '{"lonely_g1",  pt(5,5),   8'd1,  64'd0};
`ifdef BSG_CGOL_TORUS_EN
        vecs[6] = '{"glider_g32", glider, 8'd32, glider};
        vecs[7] = '{"edge_g1", edge_h, 8'd1, pt(7,3) | pt(0,3) | pt(1,3)};
`else
        vecs[6] = '{"glider_g32", glider, 8'd32, pt(6,6) | pt(6,7) | pt(7,6) | pt(7,7)};
        vecs[7] = '{"edge_g1", edge_h, 8'd1, pt(0,3) | pt(1,3)};
`endif

        reset = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0; gens_i = '0;
        v2_i = 1'b0; yumi2_i = 1'b0; data2_i = '0;
        tick();
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset v", 64'(v_o), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset ready", 64'(ready_o), 64'd1);
        chk("post_reset v", 64'(v_o), 64'd0);
        chk("post_reset board", data_o, 64'd0);

        foreach (vecs[i]) run_job(vecs[i]);

        // Backpressure: result held, stray seed ignored.
        start_job("bp", blinker_h, 8'd1);
        wait_done("bp", 1);
        for (int i = 0; i < 5; i++) begin
            data_i = 64'hFFFF_0000_FFFF_0000;
            gens_i = 8'd0;
            v_i    = (i == 2);
            tick();
            chk("bp v_held", 64'(v_o), 64'd1);
            chk("bp ready_low", 64'(ready_o), 64'd0);
            chk("bp board_stable", data_o, blinker_v);
        end
        v_i = 1'b0;
        release_result("bp");
        tick();
        chk("bp no_queued_job v", 64'(v_o), 64'd0);
        chk("bp no_queued_job board", data_o, blinker_v);

        // Reset in the middle of a long run.
        start_job("rst", blinker_h, 8'd100);
        repeat (19) tick();
        reset = 1'b1;
        #1;
        chk("rst during ready", 64'(ready_o), 64'd0);
        chk("rst during v", 64'(v_o), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rst after ready", 64'(ready_o), 64'd1);
        chk("rst after v", 64'(v_o), 64'd0);
        chk("rst after board", data_o, 64'd0);
        run_job(vecs[0]);

        // Custom rule instance B2/S-.
        data2_i = pt(4,4) | pt(4,5);
        gens_i  = 8'd1;
        chk("b2 ready", 64'(ready2_o), 64'd1);
        v2_i = 1'b1;
        tick();
        v2_i = 1'b0;
        k = 0;
        while (!v2_o && k < 50) begin
            tick();
            k++;
        end
        chk("b2 latency", 64'(k), 64'd1);
        chk("b2 board", data2_o, pt(3,4) | pt(3,5) | pt(5,4) | pt(5,5));
        yumi2_i = 1'b1;
        tick();
        yumi2_i = 1'b0;
        chk("b2 ready_after_yumi", 64'(ready2_o), 64'd1);

        frozen = data_o;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
